lcd_rect_fill: RTL
==================

LCD_RECT_FILL -- requirements
Module: lcd_rect_fill

Interface
REQ-001 Parameter HPXL, 800, horizontal pixel count of the VRAM frame.
REQ-002 Parameter VPXL, 480, vertical pixel count of the VRAM frame.
REQ-003 Port clk  in  1  the single clock for all logic.
REQ-004 Port rst_  in  1  reset, asynchronous and active-low.
REQ-005 Port iSTART  in  1  fill request, sampled only in IDLE.
REQ-006 Port iABORT  in  1  synchronous cancel of the current fill.
REQ-007 Port iX0, iX1  in  10 each  rectangle column bounds, inclusive.
REQ-008 Port iY0, iY1  in  9 each  rectangle row bounds, inclusive.
REQ-009 Port iCOLOR  in  24  fill colour, RGB888.
REQ-010 Port iWREADY  in  1  VRAM write port accepts a write this cycle.
REQ-011 Port oWE  out  1  VRAM write request.
REQ-012 Port oWADDR  out  19  VRAM linear address, equal to y*HPXL+x.
REQ-013 Port oWDATA  out  24  VRAM write data.
REQ-014 Port oBUSY  out  1  high in every state other than IDLE.
REQ-015 Port oDONE  out  1  one-cycle pulse on fill completion.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, FILL and DONE.
- IDLE->SETUP on iSTART.
- SETUP->FILL unconditionally.
- FILL->DONE when the last pixel write is accepted.
- DONE->IDLE unconditionally.
REQ-017 In IDLE, iSTART SHALL register iX0, iX1, iY0, iY1 and iCOLOR; later input changes SHALL have no effect on the fill in progress.
REQ-018 iSTART outside IDLE SHALL be ignored; no queuing.
REQ-019 SETUP SHALL clamp each X to HPXL-1 and each Y to VPXL-1.
REQ-020 SETUP SHALL then order each pair as min/max, so swapped corners fill the same rectangle.
REQ-021 SETUP SHALL load the row base as ymin*HPXL.
- The per-row base SHALL then be advanced by adding HPXL; no multiplier in the FILL loop.
REQ-022 In FILL, oWE SHALL be high with oWDATA equal to the captured colour.
REQ-023 A write is accepted only in a cycle where oWE and iWREADY are both high.
- On acceptance, the address SHALL advance x+1.
- At xmax the address SHALL wrap to xmin of the next row.
REQ-024 While iWREADY is low, oWE, oWADDR and oWDATA SHALL hold their values.
REQ-025 The first oWE SHALL appear 2 cycles after the iSTART cycle.
REQ-026 With iWREADY held high, one pixel SHALL be written per cycle with no row-change bubble.
- Total writes SHALL equal (xmax-xmin+1)*(ymax-ymin+1).
REQ-027 oDONE SHALL pulse for exactly 1 cycle, in DONE, one cycle after the last accepted write.
- oBUSY SHALL fall in the same cycle oDONE falls.
REQ-028 iABORT in SETUP or FILL SHALL go to IDLE on the next edge.
- oWE SHALL deassert on that edge, with no oDONE pulse.
- A write accepted in the abort cycle counts as written.
REQ-029 iABORT and iSTART in the same IDLE cycle: iABORT SHALL take precedence and no fill starts.
REQ-030 A single-pixel rectangle (x0=x1, y0=y1) SHALL produce exactly one write.
REQ-031 oWADDR SHALL never exceed HPXL*VPXL-1.

Reset
REQ-032 While rst_ is low, the FSM SHALL be in IDLE, asynchronously.
- oWE, oBUSY and oDONE SHALL be 0; oWADDR and oWDATA SHALL be 0.
REQ-033 Reset asserted mid-fill SHALL abandon the fill with no oDONE pulse.
- After release, the block SHALL wait for a new iSTART.

Verification
REQ-034 Single pixel: start (5,3)-(5,3), colour 0xFF0000, iWREADY=1.
- Required: one write at addr 2405, data 0xFF0000, first oWE 2 cycles after start.
- Then oDONE pulses once.
REQ-035 Rectangle: start (0,0)-(2,1), iWREADY=1.
- Required: addresses 0,1,2,800,801,802 on consecutive cycles, then oDONE.
REQ-036 Swap and clamp: start (1023,511)-(798,478).
- Required: addresses 383198,383199,383998,383999, then oDONE.
REQ-037 Backpressure: start (0,0)-(2,1) with iWREADY low for 3 cycles at address 2.
- Required: address 2 and data held for those 3 cycles.
- Remaining sequence unchanged; 6 writes total.
REQ-038 Abort and reset: iABORT at the 3rd write of (0,0)-(9,0).
- Required: IDLE next cycle, no oDONE, iSTART then accepted.
- Repeat with rst_ low mid-fill: all outputs 0 immediately.

Source files
------------

// File: rtl/lcd_rect_fill.sv
// Rectangle fill engine: writes one RGB888 colour into a VRAM rectangle.
// Latency: first write request 2 cycles after the accepted start, then one pixel per cycle.
// Backpressure: iWREADY low freezes oWE/oWADDR/oWDATA until the write is taken.
//
// Ports
//   clk, rst_          : clock and asynchronous active-low reset
//   iSTART, iABORT     : fill request (taken only in IDLE) and synchronous cancel
//   iX0/iX1, iY0/iY1   : inclusive rectangle corners, any order, clamped to the frame
//   iCOLOR             : fill colour, captured with the start request
//   iWREADY            : VRAM write port takes the current write this cycle
//   oWE/oWADDR/oWDATA  : VRAM write request, linear address y*HPXL+x, colour
//   oBUSY, oDONE       : engine active, one-cycle completion pulse

module lcd_rect_fill #(
  parameter int HPXL = 800,
  parameter int VPXL = 480
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        iSTART,
  input  logic        iABORT,
  input  logic [9:0]  iX0,
  input  logic [9:0]  iX1,
  input  logic [8:0]  iY0,
  input  logic [8:0]  iY1,
  input  logic [23:0] iCOLOR,
  input  logic        iWREADY,
  output logic        oWE,
  output logic [18:0] oWADDR,
  output logic [23:0] oWDATA,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam logic [18:0] HPXL_W = 19'(HPXL);
  localparam logic [9:0]  X_LIM  = 10'(HPXL - 1);
  localparam logic [8:0]  Y_LIM  = 9'(VPXL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Request captured at start; the fill never looks at the live inputs again.
  logic [9:0]  x0_q, x1_q;
  logic [8:0]  y0_q, y1_q;
  logic [23:0] color_q;

  // Ordered, clamped bounds and the running scan position.
  logic [9:0]  xmin_q, xmax_q, x_q;
  logic [8:0]  ymax_q, y_q;
  logic [18:0] base_q;   // address of column 0 on the current row
  logic [18:0] addr_q;   // address of the pixel currently offered

  // SETUP-time arithmetic on the captured corners.
  logic [9:0]  cx0, cx1, xmin_s, xmax_s;
  logic [8:0]  cy0, cy1, ymin_s, ymax_s;
  logic [18:0] base_s;

  logic start_take;
  logic wr_acc;
  logic row_end;
  logic last_px;

  // Abort wins over start in IDLE, so a coincident pair leaves the block idle.
  assign start_take = (state_q == S_IDLE) && iSTART && !iABORT;
  assign wr_acc     = (state_q == S_FILL) && iWREADY;
  assign row_end    = (x_q == xmax_q);
  assign last_px    = row_end && (y_q == ymax_q);

  // Clamp first, then order: swapped or off-frame corners describe the
  // same on-screen rectangle as their clamped, sorted counterparts.
  always_comb begin
    cx0    = (x0_q > X_LIM) ? X_LIM : x0_q;
    cx1    = (x1_q > X_LIM) ? X_LIM : x1_q;
    cy0    = (y0_q > Y_LIM) ? Y_LIM : y0_q;
    cy1    = (y1_q > Y_LIM) ? Y_LIM : y1_q;
    xmin_s = (cx0 <= cx1) ? cx0 : cx1;
    xmax_s = (cx0 <= cx1) ? cx1 : cx0;
    ymin_s = (cy0 <= cy1) ? cy0 : cy1;
    ymax_s = (cy0 <= cy1) ? cy1 : cy0;
    // One constant multiply per fill; rows after the first are reached by adding HPXL.
    base_s = 19'(ymin_s) * HPXL_W;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_take) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = iABORT ? S_IDLE : S_FILL;
      end
      S_FILL: begin
        // An abort still lets a write accepted in the same cycle stand,
        // but no completion is reported.
        if (iABORT) begin
          state_d = S_IDLE;
        end else if (wr_acc && last_px) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // Address and data are forced to zero outside FILL so that the bus is
  // quiet when idle and never shows an out-of-frame address.
  always_comb begin
    oWE    = 1'b0;
    oWADDR = '0;
    oWDATA = '0;
    oBUSY  = (state_q != S_IDLE);
    oDONE  = 1'b0;
    unique case (state_q)
      S_FILL: begin
        oWE    = 1'b1;
        oWADDR = addr_q;
        oWDATA = color_q;
      end
      S_DONE: begin
        oDONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (start_take) begin
      x0_q    <= iX0;
      x1_q    <= iX1;
      y0_q    <= iY0;
      y1_q    <= iY1;
      color_q <= iCOLOR;
    end
  end

  // ---------------------------------------------------------------------
  // Scan position and address generation
  // ---------------------------------------------------------------------
  // SETUP preloads the first pixel so FILL can offer a write immediately.
  // On each accepted write the address steps by one; at the row end it
  // jumps to xmin of the next row in the same cycle, so there is no bubble.
  // Nothing advances on the final pixel, keeping every address in frame.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else if (state_q == S_SETUP) begin
      xmin_q <= xmin_s;
      xmax_q <= xmax_s;
      ymax_q <= ymax_s;
      x_q    <= xmin_s;
      y_q    <= ymin_s;
      base_q <= base_s;
      addr_q <= base_s + 19'(xmin_s);
    end else if (wr_acc && !last_px) begin
      if (row_end) begin
        x_q    <= xmin_q;
        y_q    <= y_q + 9'd1;
        base_q <= base_q + HPXL_W;
        addr_q <= base_q + HPXL_W + 19'(xmin_q);
      end else begin
        x_q    <= x_q + 10'd1;
        addr_q <= addr_q + 19'd1;
      end
    end
  end

endmodule
